// File: rtl/alu_pipe_datapath_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pipe_datapath_if                                                 |
// | Issue, result/flags and debug-read bundle for alu_pipe_datapath.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_pipe_datapath_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 16
);
    localparam int c_ADDR_W = $clog2(NUM_REGS);

    logic                issue_valid;
    logic [3:0]          op;
    logic [c_ADDR_W-1:0] dest;
    logic [c_ADDR_W-1:0] src_a;
    logic [c_ADDR_W-1:0] src_b;
    logic                use_imm;
    logic [WIDTH-1:0]    immediate;
    logic                wb_en;
    logic                flags_en;
    logic [WIDTH-1:0]    result;
    logic                result_valid;
    logic [4:0]          flags;
    logic [c_ADDR_W-1:0] dbg_addr;
    logic [WIDTH-1:0]    dbg_data;

    modport master (
        output issue_valid, op, dest, src_a, src_b, use_imm, immediate,
               wb_en, flags_en, dbg_addr,
        input  result, result_valid, flags, dbg_data
    );

    modport slave (
        input  issue_valid, op, dest, src_a, src_b, use_imm, immediate,
               wb_en, flags_en, dbg_addr,
        output result, result_valid, flags, dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pipe_datapath                                                    |
// | Two-stage register-file/ALU datapath with result and flag forwarding.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_pipe_datapath #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 16
) (
    input  wire logic          clock,
    input  wire logic          reset,
    alu_pipe_datapath_if.slave bus
);
    localparam int c_ADDR_W  = $clog2(NUM_REGS);
    localparam int c_SHIFT_W = $clog2(WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_ADDC = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_CMP  = 4'd3;
    localparam logic [3:0] c_OP_AND  = 4'd4;
    localparam logic [3:0] c_OP_OR   = 4'd5;
    localparam logic [3:0] c_OP_XOR  = 4'd6;
    localparam logic [3:0] c_OP_NOT  = 4'd7;
    localparam logic [3:0] c_OP_MOV  = 4'd8;
    localparam logic [3:0] c_OP_LSH  = 4'd9;
    localparam logic [3:0] c_OP_RSH  = 4'd10;
    localparam logic [3:0] c_OP_ASH  = 4'd11;

    logic [WIDTH-1:0]     r_regs [NUM_REGS];
    logic                 r_exValid;
    logic                 r_exWb;
    logic                 r_exFlagsEn;
    logic [3:0]           r_exOp;
    logic [c_ADDR_W-1:0]  r_exDest;
    logic [WIDTH-1:0]     r_exA;
    logic [WIDTH-1:0]     r_exB;
    logic [WIDTH-1:0]     r_result;
    logic                 r_resultValid;
    logic [4:0]           r_flags;

    logic [WIDTH-1:0]     w_aluOut;
    logic [4:0]           w_flagsNext;
    logic                 w_opWrites;
    logic                 w_exWrites;
    logic                 w_fwdA;
    logic                 w_fwdB;
    logic [WIDTH-1:0]     w_opA;
    logic [WIDTH-1:0]     w_opB;
    logic                 w_cin;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [c_SHIFT_W-1:0] w_shamt;
    logic                 w_aMsb;
    logic                 w_bMsb;

    // Operand read with bypass from the EX stage's combinational result.
    assign w_exWrites = r_exValid && r_exWb && w_opWrites;
    assign w_fwdA     = w_exWrites && (r_exDest == bus.src_a);
    assign w_fwdB     = w_exWrites && (r_exDest == bus.src_b);
    assign w_opA      = w_fwdA ? w_aluOut : r_regs[bus.src_a];
    assign w_opB      = bus.use_imm ? bus.immediate
                                    : (w_fwdB ? w_aluOut : r_regs[bus.src_b]);

    // The previous op has already retired its flags, so r_flags[0] is the live carry.
    assign w_cin   = (r_exOp == c_OP_ADDC) && r_flags[0];
    assign w_sum   = {1'b0, r_exA} + {1'b0, r_exB} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff  = {1'b0, r_exA} - {1'b0, r_exB};
    assign w_shamt = r_exB[c_SHIFT_W-1:0];
    assign w_aMsb  = r_exA[WIDTH-1];
    assign w_bMsb  = r_exB[WIDTH-1];

    always_comb begin
        w_aluOut    = '0;
        w_flagsNext = r_flags;
        w_opWrites  = 1'b1;
        case (r_exOp)
            c_OP_ADD, c_OP_ADDC: begin
                w_aluOut       = w_sum[WIDTH-1:0];
                w_flagsNext[0] = w_sum[WIDTH];
                w_flagsNext[2] = (w_aMsb == w_bMsb) && (w_sum[WIDTH-1] != w_aMsb);
            end
            c_OP_SUB: begin
                w_aluOut       = w_diff[WIDTH-1:0];
                w_flagsNext[0] = w_diff[WIDTH];
                w_flagsNext[2] = (w_aMsb != w_bMsb) && (w_diff[WIDTH-1] != w_aMsb);
            end
            c_OP_CMP: begin
                w_aluOut       = w_diff[WIDTH-1:0];
                w_opWrites     = 1'b0;
                w_flagsNext[1] = w_diff[WIDTH];
                w_flagsNext[3] = (r_exA == r_exB);
                w_flagsNext[4] = ($signed(r_exA) < $signed(r_exB));
            end
            c_OP_AND: w_aluOut = r_exA & r_exB;
            c_OP_OR:  w_aluOut = r_exA | r_exB;
            c_OP_XOR: w_aluOut = r_exA ^ r_exB;
            c_OP_NOT: w_aluOut = ~r_exA;
            c_OP_MOV: w_aluOut = r_exB;
            c_OP_LSH: w_aluOut = r_exA << w_shamt;
            c_OP_RSH: w_aluOut = r_exA >> w_shamt;
            c_OP_ASH: w_aluOut = $unsigned($signed(r_exA) >>> w_shamt);
            default:  w_opWrites = 1'b0;
        endcase
        if (w_opWrites) begin
            w_flagsNext[3] = (w_aluOut == '0);
            w_flagsNext[4] = w_aluOut[WIDTH-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_exValid     <= 1'b0;
            r_exWb        <= 1'b0;
            r_exFlagsEn   <= 1'b0;
            r_exOp        <= '0;
            r_exDest      <= '0;
            r_exA         <= '0;
            r_exB         <= '0;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_flags       <= '0;
        end else begin
            r_exValid <= bus.issue_valid;
            if (bus.issue_valid) begin
                r_exOp      <= bus.op;
                r_exDest    <= bus.dest;
                r_exA       <= w_opA;
                r_exB       <= w_opB;
                r_exWb      <= bus.wb_en;
                r_exFlagsEn <= bus.flags_en;
            end
            if (w_exWrites) begin
                r_regs[r_exDest] <= w_aluOut;
            end
            if (r_exValid && r_exFlagsEn) begin
                r_flags <= w_flagsNext;
            end
            if (r_exValid) begin
                r_result <= w_aluOut;
            end
            r_resultValid <= r_exValid;
        end
    end

    assign bus.result       = r_result;
    assign bus.result_valid = r_resultValid;
    assign bus.flags        = r_flags;
    assign bus.dbg_data     = r_regs[bus.dbg_addr];
endmodule
`default_nettype wire
